// File: rtl/dfx_seq_pkg.sv
// Shared definitions for the DFX sequencer: bank-1 field codes, slot status
// encodings and the default bank-1 widths used by the table and the AXI slaves.
package dfx_seq_pkg;

  localparam int unsigned B1_INDEX_WIDTH    = 2;
  localparam int unsigned B1_SRC_ADDR_WIDTH = 32;
  localparam int unsigned B1_SRC_SIZE_WIDTH = 26;
  localparam int unsigned B1_DST_ADDR_WIDTH = 32;
  localparam int unsigned B1_DST_SIZE_WIDTH = 26;
  localparam int unsigned B1_STATUS_WIDTH   = 2;
  localparam int unsigned B1_PROFILE_WIDTH  = 32;

  // Field select codes, equal to AXI address bits [5:2]
  localparam logic [3:0] FLD_SRC_ADDR = 4'd0;
  localparam logic [3:0] FLD_SRC_SIZE = 4'd1;
  localparam logic [3:0] FLD_DES_ADDR = 4'd2;
  localparam logic [3:0] FLD_DES_SIZE = 4'd3;
  localparam logic [3:0] FLD_STATUS   = 4'd4;
  localparam logic [3:0] FLD_PROFILE  = 4'd5;

  typedef enum logic [1:0] {
    ST_SLOT_IDLE = 2'd0,
    ST_SLOT_BUSY = 2'd1,
    ST_SLOT_DONE = 2'd2,
    ST_SLOT_ERR  = 2'd3
  } slot_status_e;

endpackage

// File: rtl/bank1_slot.sv
// One bank-1 descriptor slot: field storage, write-priority resolution and
// the saturating busy-cycle profile counter.
module bank1_slot
  import dfx_seq_pkg::*;
#(
  parameter int unsigned SRC_ADDR_WIDTH = B1_SRC_ADDR_WIDTH,
  parameter int unsigned SRC_SIZE_WIDTH = B1_SRC_SIZE_WIDTH,
  parameter int unsigned DST_ADDR_WIDTH = B1_DST_ADDR_WIDTH,
  parameter int unsigned DST_SIZE_WIDTH = B1_DST_SIZE_WIDTH,
  parameter int unsigned STATUS_WIDTH   = B1_STATUS_WIDTH,
  parameter int unsigned PROFILE_WIDTH  = B1_PROFILE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [3:0]                wr_field,
  input  logic [31:0]               wr_data,
  input  logic                      seq_busy,
  input  logic                      seq_status_we,
  input  logic [STATUS_WIDTH-1:0]   seq_status,
  output logic [SRC_ADDR_WIDTH-1:0] src_addr,
  output logic [SRC_SIZE_WIDTH-1:0] src_size,
  output logic [DST_ADDR_WIDTH-1:0] des_addr,
  output logic [DST_SIZE_WIDTH-1:0] des_size,
  output logic [STATUS_WIDTH-1:0]   status,
  output logic [PROFILE_WIDTH-1:0]  profile
);

  always_ff @(posedge clk) begin
    if (reset) begin
      src_addr <= '0;
      src_size <= '0;
      des_addr <= '0;
      des_size <= '0;
      status   <= '0;
      profile  <= '0;
    end else begin
      if (wr_en) begin
        case (wr_field)
          FLD_SRC_ADDR: src_addr <= SRC_ADDR_WIDTH'(wr_data);
          FLD_SRC_SIZE: src_size <= SRC_SIZE_WIDTH'(wr_data);
          FLD_DES_ADDR: des_addr <= DST_ADDR_WIDTH'(wr_data);
          FLD_DES_SIZE: des_size <= DST_SIZE_WIDTH'(wr_data);
          default: ;
        endcase
      end

      // Sequencer status update beats a same-cycle AXI status write
      if (seq_status_we)
        status <= seq_status;
      else if (wr_en && wr_field == FLD_STATUS)
        status <= STATUS_WIDTH'(wr_data);

      // AXI load beats the increment and is taken exactly
      if (wr_en && wr_field == FLD_PROFILE)
        profile <= PROFILE_WIDTH'(wr_data);
      else if (seq_busy && profile != '1)
        profile <= profile + PROFILE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/bank1_slot_table.sv
// Bank-1 DMA descriptor table: per-slot storage, AXI write port, and a
// req/ready read port that freezes a registered snapshot while held.
module bank1_slot_table
  import dfx_seq_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH    = B1_INDEX_WIDTH,
  parameter int unsigned SRC_ADDR_WIDTH = B1_SRC_ADDR_WIDTH,
  parameter int unsigned SRC_SIZE_WIDTH = B1_SRC_SIZE_WIDTH,
  parameter int unsigned DST_ADDR_WIDTH = B1_DST_ADDR_WIDTH,
  parameter int unsigned DST_SIZE_WIDTH = B1_DST_SIZE_WIDTH,
  parameter int unsigned STATUS_WIDTH   = B1_STATUS_WIDTH,
  parameter int unsigned PROFILE_WIDTH  = B1_PROFILE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [INDEX_WIDTH-1:0]    wr_index,
  input  logic [3:0]                wr_field,
  input  logic [31:0]               wr_data,
  input  logic [INDEX_WIDTH-1:0]    ext_bank1_out_index,
  input  logic                      ext_bank1_out_req,
  output logic [SRC_ADDR_WIDTH-1:0] ext_bank1_out_src_addr,
  output logic [SRC_SIZE_WIDTH-1:0] ext_bank1_out_src_size,
  output logic [DST_ADDR_WIDTH-1:0] ext_bank1_out_des_addr,
  output logic [DST_SIZE_WIDTH-1:0] ext_bank1_out_des_size,
  output logic [STATUS_WIDTH-1:0]   ext_bank1_out_status,
  output logic [PROFILE_WIDTH-1:0]  ext_bank1_out_profile,
  output logic                      ext_bank1_out_ready,
  input  logic [INDEX_WIDTH-1:0]    seq_index,
  input  logic                      seq_busy,
  input  logic                      seq_status_we,
  input  logic [STATUS_WIDTH-1:0]   seq_status
);

  localparam int unsigned NUM_SLOTS = 2 ** INDEX_WIDTH;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_HOLD = 1'b1
  } rd_state_e;

  logic [SRC_ADDR_WIDTH-1:0] slot_src_addr [NUM_SLOTS];
  logic [SRC_SIZE_WIDTH-1:0] slot_src_size [NUM_SLOTS];
  logic [DST_ADDR_WIDTH-1:0] slot_des_addr [NUM_SLOTS];
  logic [DST_SIZE_WIDTH-1:0] slot_des_size [NUM_SLOTS];
  logic [STATUS_WIDTH-1:0]   slot_status   [NUM_SLOTS];
  logic [PROFILE_WIDTH-1:0]  slot_profile  [NUM_SLOTS];

  logic wr_fire;

  assign wr_ready = ~reset;
  assign wr_fire  = wr_valid & wr_ready;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    bank1_slot #(
      .SRC_ADDR_WIDTH (SRC_ADDR_WIDTH),
      .SRC_SIZE_WIDTH (SRC_SIZE_WIDTH),
      .DST_ADDR_WIDTH (DST_ADDR_WIDTH),
      .DST_SIZE_WIDTH (DST_SIZE_WIDTH),
      .STATUS_WIDTH   (STATUS_WIDTH),
      .PROFILE_WIDTH  (PROFILE_WIDTH)
    ) u_slot (
      .clk           (clk),
      .reset         (reset),
      .wr_en         (wr_fire && (wr_index == INDEX_WIDTH'(i))),
      .wr_field      (wr_field),
      .wr_data       (wr_data),
      .seq_busy      (seq_busy && (seq_index == INDEX_WIDTH'(i))),
      .seq_status_we (seq_status_we && (seq_index == INDEX_WIDTH'(i))),
      .seq_status    (seq_status),
      .src_addr      (slot_src_addr[i]),
      .src_size      (slot_src_size[i]),
      .des_addr      (slot_des_addr[i]),
      .des_size      (slot_des_size[i]),
      .status        (slot_status[i]),
      .profile       (slot_profile[i])
    );
  end

  rd_state_e              rd_state, rd_state_d;
  logic [INDEX_WIDTH-1:0] held_index;
  logic                   capture;

  always_ff @(posedge clk) begin
    if (reset) rd_state <= R_IDLE;
    else       rd_state <= rd_state_d;
  end

  // An index change under a held req drops to idle for one cycle, then recaptures
  always_comb begin
    rd_state_d = rd_state;
    capture    = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (ext_bank1_out_req) begin
          rd_state_d = R_HOLD;
          capture    = 1'b1;
        end
      end
      R_HOLD: begin
        if (!ext_bank1_out_req || ext_bank1_out_index != held_index)
          rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_index             <= '0;
      ext_bank1_out_src_addr <= '0;
      ext_bank1_out_src_size <= '0;
      ext_bank1_out_des_addr <= '0;
      ext_bank1_out_des_size <= '0;
      ext_bank1_out_status   <= '0;
      ext_bank1_out_profile  <= '0;
    end else if (capture) begin
      held_index             <= ext_bank1_out_index;
      ext_bank1_out_src_addr <= slot_src_addr[ext_bank1_out_index];
      ext_bank1_out_src_size <= slot_src_size[ext_bank1_out_index];
      ext_bank1_out_des_addr <= slot_des_addr[ext_bank1_out_index];
      ext_bank1_out_des_size <= slot_des_size[ext_bank1_out_index];
      ext_bank1_out_status   <= slot_status[ext_bank1_out_index];
      ext_bank1_out_profile  <= slot_profile[ext_bank1_out_index];
    end
  end

  assign ext_bank1_out_ready = (rd_state == R_HOLD);

endmodule

// File: tb/tb_bank1_slot_table.sv
// Directed plus randomized bench for bank1_slot_table against a per-slot
// behavioural model of the descriptor table and its read snapshot.
module tb_bank1_slot_table;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_index;
  logic [3:0]  wr_field;
  logic [31:0] wr_data;
  logic [1:0]  rd_index;
  logic        rd_req;
  logic [31:0] o_src_addr;
  logic [25:0] o_src_size;
  logic [31:0] o_des_addr;
  logic [25:0] o_des_size;
  logic [1:0]  o_status;
  logic [31:0] o_profile;
  logic        o_ready;
  logic [1:0]  seq_index;
  logic        seq_busy;
  logic        seq_status_we;
  logic [1:0]  seq_status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bank1_slot_table #(
    .INDEX_WIDTH    (2),
    .SRC_ADDR_WIDTH (32),
    .SRC_SIZE_WIDTH (26),
    .DST_ADDR_WIDTH (32),
    .DST_SIZE_WIDTH (26),
    .STATUS_WIDTH   (2),
    .PROFILE_WIDTH  (32)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .wr_valid               (wr_valid),
    .wr_ready               (wr_ready),
    .wr_index               (wr_index),
    .wr_field               (wr_field),
    .wr_data                (wr_data),
    .ext_bank1_out_index    (rd_index),
    .ext_bank1_out_req      (rd_req),
    .ext_bank1_out_src_addr (o_src_addr),
    .ext_bank1_out_src_size (o_src_size),
    .ext_bank1_out_des_addr (o_des_addr),
    .ext_bank1_out_des_size (o_des_size),
    .ext_bank1_out_status   (o_status),
    .ext_bank1_out_profile  (o_profile),
    .ext_bank1_out_ready    (o_ready),
    .seq_index              (seq_index),
    .seq_busy               (seq_busy),
    .seq_status_we          (seq_status_we),
    .seq_status             (seq_status)
  );

  // Model: table contents plus the reader-visible snapshot
  logic [31:0] m_fld [4][6];
  logic [31:0] m_snap [6];
  logic        m_ready = 1'b0;
  logic [1:0]  m_idx = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("wr_ready", 32'(wr_ready), 32'(!reset));
    check("ready",    32'(o_ready),    32'(m_ready));
    check("src_addr", o_src_addr,      m_snap[0]);
    check("src_size", 32'(o_src_size), m_snap[1]);
    check("des_addr", o_des_addr,      m_snap[2]);
    check("des_size", 32'(o_des_size), m_snap[3]);
    check("status",   32'(o_status),   m_snap[4]);
    check("profile",  o_profile,       m_snap[5]);
  endtask

  // Apply one clock edge to the model from the currently driven inputs
  task automatic model_edge();
    if (reset) begin
      for (int unsigned s = 0; s < 4; s++)
        for (int unsigned f = 0; f < 6; f++) m_fld[s][f] = 0;
      for (int unsigned f = 0; f < 6; f++) m_snap[f] = 0;
      m_ready = 1'b0;
    end else begin
      if (!m_ready && rd_req) begin
        for (int unsigned f = 0; f < 6; f++) m_snap[f] = m_fld[rd_index][f];
        m_idx   = rd_index;
        m_ready = 1'b1;
      end else if (m_ready && (!rd_req || rd_index != m_idx)) begin
        m_ready = 1'b0;
      end
      if (seq_busy && m_fld[seq_index][5] != 32'hFFFF_FFFF)
        m_fld[seq_index][5] = m_fld[seq_index][5] + 1;
      if (wr_valid) begin
        case (wr_field)
          4'd0: m_fld[wr_index][0] = wr_data;
          4'd1: m_fld[wr_index][1] = wr_data & 32'h03FF_FFFF;
          4'd2: m_fld[wr_index][2] = wr_data;
          4'd3: m_fld[wr_index][3] = wr_data & 32'h03FF_FFFF;
          4'd4: m_fld[wr_index][4] = wr_data & 32'h3;
          4'd5: m_fld[wr_index][5] = wr_data;
          default: ;
        endcase
      end
      if (seq_status_we) m_fld[seq_index][4] = 32'(seq_status);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic quiet();
    wr_valid = 1'b0; seq_busy = 1'b0; seq_status_we = 1'b0;
  endtask

  task automatic axi_write(input logic [1:0] idx, input logic [3:0] fld, input logic [31:0] data);
    wr_valid = 1'b1; wr_index = idx; wr_field = fld; wr_data = data;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_slot(input logic [1:0] idx);
    rd_req = 1'b1; rd_index = idx;
    tick();
    check("read_ready", 32'(o_ready), 32'd1);
    rd_req = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; rd_index = '0;
    wr_index = '0; wr_field = '0; wr_data = '0;
    seq_index = '0; seq_status = '0;
    quiet();
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset_ready", 32'(o_ready), 32'd0);

    // Read of slot 2 straight after reset
    rd_req = 1'b1; rd_index = 2'd2;
    tick();
    check("rd2_ready", 32'(o_ready), 32'd1);
    check("rd2_profile", o_profile, 32'd0);
    rd_req = 1'b0;
    tick();

    // src_size truncation
    axi_write(2'd1, 4'd1, 32'hFFFF_FFFF);
    read_slot(2'd1);
    check("src_size_trunc", 32'(o_src_size), 32'h03FF_FFFF);

    // Profile saturation
    axi_write(2'd3, 4'd5, 32'hFFFF_FFFD);
    seq_index = 2'd3; seq_busy = 1'b1;
    repeat (5) tick();
    seq_busy = 1'b0;
    read_slot(2'd3);
    check("prof_sat", o_profile, 32'hFFFF_FFFF);

    // Same-slot conflicts
    wr_valid = 1'b1; wr_index = 2'd0; wr_field = 4'd4; wr_data = 32'd1;
    seq_index = 2'd0; seq_status_we = 1'b1; seq_status = 2'd3;
    tick();
    quiet();
    wr_valid = 1'b1; wr_index = 2'd0; wr_field = 4'd5; wr_data = 32'd7;
    seq_index = 2'd0; seq_busy = 1'b1;
    tick();
    quiet();
    read_slot(2'd0);
    check("conf_status", 32'(o_status), 32'd3);
    check("conf_profile", o_profile, 32'd7);

    // Snapshot frozen while held
    rd_req = 1'b1; rd_index = 2'd0;
    tick();
    axi_write(2'd0, 4'd0, 32'h0000_1234);
    tick();
    check("held_src", o_src_addr, 32'd0);
    rd_req = 1'b0;
    tick();
    read_slot(2'd0);
    check("reread_src", o_src_addr, 32'h0000_1234);

    // Index change under held req: one idle cycle then recapture
    rd_req = 1'b1; rd_index = 2'd0;
    tick();
    rd_index = 2'd1;
    tick();
    check("idxchg_drop", 32'(o_ready), 32'd0);
    tick();
    check("idxchg_recap", 32'(o_ready), 32'd1);
    check("idxchg_size", 32'(o_src_size), 32'h03FF_FFFF);
    rd_req = 1'b0;
    tick();

    // Randomized traffic
    for (int unsigned n = 0; n < 600; n++) begin
      reset         = ($urandom_range(0, 79) == 0);
      wr_valid      = 1'($urandom_range(0, 1));
      wr_index      = 2'($urandom_range(0, 3));
      wr_field      = 4'($urandom_range(0, 15));
      wr_data       = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      seq_index     = 2'($urandom_range(0, 3));
      seq_busy      = ($urandom_range(0, 3) != 0);
      seq_status_we = 1'($urandom_range(0, 1));
      seq_status    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rd_req = ~rd_req;
      if ($urandom_range(0, 5) == 0) rd_index = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 1'b0;
    quiet();
    rd_req = 1'b0;
    tick();

    // Reset while holding a read
    axi_write(2'd3, 4'd2, 32'hCAFE_0001);
    rd_req = 1'b1; rd_index = 2'd3;
    tick();
    check("pre_rst_hold", 32'(o_ready), 32'd1);
    reset = 1'b1;
    tick();
    check("rst_hold_drop", 32'(o_ready), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(o_ready), 32'd1);
    check("post_rst_des", o_des_addr, 32'd0);
    rd_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
